// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory-access pipeline stage.
// Covers FSM states, access-size codes, and lane/legality helpers.
package mem_stage_pkg;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr;
            SZ_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // The memory picks its lane by byte enable, so every lane carries a copy.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            SZ_BYTE: w = {4{d[7:0]}};
            SZ_HALF: w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic access_legal(input logic [1:0] size, input logic [1:0] addr,
                                          input logic rd, input logic wr);
        logic ok;
        ok = !(rd && wr);
        case (size)
            SZ_BYTE: ;
            SZ_HALF: if (addr[0]) ok = 1'b0;
            SZ_WORD: if (addr != 2'b00) ok = 1'b0;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: selects the addressed byte/half of the read word
// and sign- or zero-extends it to 32 bits.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[{addr, 3'b000} +: 8];
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: data = {{24{sgn & b[7]}}, b};
            SZ_HALF: data = {{16{sgn & h[15]}}, h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: ALU results pass through in one cycle,
// loads/stores run a req/ack handshake and stall EX while outstanding.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              RegClk,
    input  logic              Reset,
    input  logic              EXValid,
    input  logic [4:0]        EXRd,
    input  logic [31:0]       EXAluResult,
    input  logic [31:0]       EXStoreData,
    input  logic              EXMemRead,
    input  logic              EXMemWrite,
    input  logic [1:0]        EXMemSize,
    input  logic              EXMemSigned,
    input  logic              EXRegWrite,
    output logic              MEMStall,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemWData,
    output logic [3:0]        MemByteEn,
    input  logic [31:0]       MemRData,
    input  logic              MemAck,
    output logic [4:0]        MEMRd,
    output logic [31:0]       MEMData,
    output logic              MEMRegWrite,
    output logic              MisalignErr
);

    state_t      state_q, state_d;
    logic [4:0]  cap_rd;
    logic        cap_rw;
    logic        cap_load;
    logic [1:0]  cap_size;
    logic        cap_signed;
    logic [1:0]  cap_addr;
    logic        mem_op;
    logic        legal;
    logic [31:0] load_val;

    assign MEMStall = (state_q == ACCESS);

    always_comb begin
        mem_op = EXMemRead | EXMemWrite;
        legal  = access_legal(EXMemSize, EXAluResult[1:0], EXMemRead, EXMemWrite);
    end

    always_ff @(posedge RegClk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (EXValid && mem_op && legal) state_d = ACCESS;
            ACCESS:  if (MemAck) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    mem_load_align u_align (
        .rdata (MemRData),
        .addr  (cap_addr),
        .size  (cap_size),
        .sgn   (cap_signed),
        .data  (load_val)
    );

    always_ff @(posedge RegClk) begin
        if (Reset) begin
            MemReq      <= 1'b0;
            MemWe       <= 1'b0;
            MemAddr     <= '0;
            MemWData    <= '0;
            MemByteEn   <= '0;
            MEMRd       <= '0;
            MEMData     <= '0;
            MEMRegWrite <= 1'b0;
            MisalignErr <= 1'b0;
            cap_rd      <= '0;
            cap_rw      <= 1'b0;
            cap_load    <= 1'b0;
            cap_size    <= '0;
            cap_signed  <= 1'b0;
            cap_addr    <= '0;
        end else begin
            // Write-back sees a bubble unless a result retires this cycle.
            MEMRegWrite <= 1'b0;
            MisalignErr <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (EXValid) begin
                        if (!mem_op) begin
                            MEMRd       <= EXRd;
                            MEMData     <= EXAluResult;
                            MEMRegWrite <= EXRegWrite;
                        end else if (!legal) begin
                            MisalignErr <= 1'b1;
                        end else begin
                            cap_rd     <= EXRd;
                            cap_rw     <= EXRegWrite;
                            cap_load   <= EXMemRead;
                            cap_size   <= EXMemSize;
                            cap_signed <= EXMemSigned;
                            cap_addr   <= EXAluResult[1:0];
                            MemReq     <= 1'b1;
                            MemWe      <= EXMemWrite;
                            MemAddr    <= EXAluResult[ADDR_W-1:0];
                            MemWData   <= store_lanes(EXMemSize, EXStoreData);
                            MemByteEn  <= byte_en(EXMemSize, EXAluResult[1:0]);
                        end
                    end
                end
                ACCESS: begin
                    if (MemAck) begin
                        MemReq <= 1'b0;
                        if (cap_load) begin
                            MEMData     <= load_val;
                            MEMRd       <= cap_rd;
                            MEMRegWrite <= cap_rw;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads with waits, byte/half
// lanes, illegal accesses, and reset during an outstanding access.
module tb_mem_stage;

    logic        RegClk = 1'b0;
    logic        Reset;
    logic        EXValid;
    logic [4:0]  EXRd;
    logic [31:0] EXAluResult;
    logic [31:0] EXStoreData;
    logic        EXMemRead;
    logic        EXMemWrite;
    logic [1:0]  EXMemSize;
    logic        EXMemSigned;
    logic        EXRegWrite;
    logic        MEMStall;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemByteEn;
    logic [31:0] MemRData;
    logic        MemAck;
    logic [4:0]  MEMRd;
    logic [31:0] MEMData;
    logic        MEMRegWrite;
    logic        MisalignErr;

    int total = 0;
    int bad   = 0;

    always #5 RegClk = ~RegClk;

    mem_stage #(.ADDR_W(32)) dut (
        .RegClk      (RegClk),
        .Reset       (Reset),
        .EXValid     (EXValid),
        .EXRd        (EXRd),
        .EXAluResult (EXAluResult),
        .EXStoreData (EXStoreData),
        .EXMemRead   (EXMemRead),
        .EXMemWrite  (EXMemWrite),
        .EXMemSize   (EXMemSize),
        .EXMemSigned (EXMemSigned),
        .EXRegWrite  (EXRegWrite),
        .MEMStall    (MEMStall),
        .MemReq      (MemReq),
        .MemWe       (MemWe),
        .MemAddr     (MemAddr),
        .MemWData    (MemWData),
        .MemByteEn   (MemByteEn),
        .MemRData    (MemRData),
        .MemAck      (MemAck),
        .MEMRd       (MEMRd),
        .MEMData     (MEMData),
        .MEMRegWrite (MEMRegWrite),
        .MisalignErr (MisalignErr)
    );

    task automatic step();
        @(posedge RegClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ex_mem(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input logic [4:0] rdst, input logic rw);
        EXValid = 1'b1; EXMemRead = rd; EXMemWrite = wr; EXMemSize = sz; EXMemSigned = sg;
        EXAluResult = addr; EXStoreData = sd; EXRd = rdst; EXRegWrite = rw;
    endtask

    initial begin
        Reset = 1'b1; EXValid = 1'b0; EXRd = '0; EXAluResult = '0; EXStoreData = '0;
        EXMemRead = 1'b0; EXMemWrite = 1'b0; EXMemSize = 2'b00; EXMemSigned = 1'b0;
        EXRegWrite = 1'b0; MemRData = '0; MemAck = 1'b0;
        step(); step();
        chk("rst_memrd", 32'(MEMRd), 32'h0);
        chk("rst_memdata", MEMData, 32'h0);
        chk("rst_regwr", 32'(MEMRegWrite), 32'h0);
        chk("rst_req", 32'(MemReq), 32'h0);
        chk("rst_we", 32'(MemWe), 32'h0);
        chk("rst_addr", MemAddr, 32'h0);
        chk("rst_wdata", MemWData, 32'h0);
        chk("rst_be", 32'(MemByteEn), 32'h0);
        chk("rst_err", 32'(MisalignErr), 32'h0);
        chk("rst_stall", 32'(MEMStall), 32'h0);
        Reset = 1'b0;

        // ALU pass-through
        EXValid = 1'b1; EXRd = 5'd5; EXAluResult = 32'h1234; EXRegWrite = 1'b1;
        step();
        chk("alu_rd", 32'(MEMRd), 32'd5);
        chk("alu_data", MEMData, 32'h1234);
        chk("alu_regwr", 32'(MEMRegWrite), 32'h1);
        chk("alu_noreq", 32'(MemReq), 32'h0);
        EXValid = 1'b0;
        step();
        chk("bubble_regwr", 32'(MEMRegWrite), 32'h0);
        chk("bubble_hold", MEMData, 32'h1234);

        // Word load, three wait cycles
        ex_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd7, 1'b1);
        step();
        chk("wl_req", 32'(MemReq), 32'h1);
        chk("wl_we", 32'(MemWe), 32'h0);
        chk("wl_addr", MemAddr, 32'h100);
        chk("wl_be", 32'(MemByteEn), 32'hF);
        chk("wl_regwr0", 32'(MEMRegWrite), 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("wl_stall", 32'(MEMStall), 32'h1);
            chk("wl_req_hold", 32'(MemReq), 32'h1);
            if (i == 3) begin
                MemAck = 1'b1; MemRData = 32'hDEADBEEF;
            end
            step();
        end
        MemAck = 1'b0; EXValid = 1'b0;
        chk("wl_stall_end", 32'(MEMStall), 32'h0);
        chk("wl_req_drop", 32'(MemReq), 32'h0);
        chk("wl_data", MEMData, 32'hDEADBEEF);
        chk("wl_rd", 32'(MEMRd), 32'd7);
        chk("wl_regwr", 32'(MEMRegWrite), 32'h1);

        // Signed byte load from lane 3
        ex_mem(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd3, 1'b1);
        step();
        chk("sb_be", 32'(MemByteEn), 32'h8);
        chk("sb_addr", MemAddr, 32'h103);
        MemAck = 1'b1; MemRData = 32'h80000000;
        step();
        MemAck = 1'b0; EXValid = 1'b0;
        chk("sb_data", MEMData, 32'hFFFFFF80);
        chk("sb_rd", 32'(MEMRd), 32'd3);
        chk("sb_regwr", 32'(MEMRegWrite), 32'h1);

        // Same byte load, zero-extended
        ex_mem(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd4, 1'b1);
        step();
        MemAck = 1'b1; MemRData = 32'h80000000;
        step();
        MemAck = 1'b0; EXValid = 1'b0;
        chk("ub_data", MEMData, 32'h00000080);

        // Signed half load from upper half
        ex_mem(1'b1, 1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 5'd9, 1'b1);
        step();
        chk("sh_be", 32'(MemByteEn), 32'hC);
        MemAck = 1'b1; MemRData = 32'h9ABC1234;
        step();
        MemAck = 1'b0; EXValid = 1'b0;
        chk("sh_data", MEMData, 32'hFFFF9ABC);

        // Half store
        ex_mem(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'hABCD, 5'd6, 1'b0);
        step();
        chk("hs_req", 32'(MemReq), 32'h1);
        chk("hs_we", 32'(MemWe), 32'h1);
        chk("hs_be", 32'(MemByteEn), 32'hC);
        chk("hs_wdata", MemWData, 32'hABCDABCD);
        chk("hs_regwr", 32'(MEMRegWrite), 32'h0);
        MemAck = 1'b1;
        step();
        MemAck = 1'b0; EXValid = 1'b0;
        chk("hs_req_drop", 32'(MemReq), 32'h0);
        chk("hs_regwr_ack", 32'(MEMRegWrite), 32'h0);
        chk("hs_stall", 32'(MEMStall), 32'h0);

        // Byte store at lane 1
        ex_mem(1'b0, 1'b1, 2'b00, 1'b0, 32'h201, 32'h12345677, 5'd0, 1'b0);
        step();
        chk("bs_be", 32'(MemByteEn), 32'h2);
        chk("bs_wdata", MemWData, 32'h77777777);
        MemAck = 1'b1;
        step();
        MemAck = 1'b0; EXValid = 1'b0;

        // Misaligned word load
        ex_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd8, 1'b1);
        step();
        chk("mis_err", 32'(MisalignErr), 32'h1);
        chk("mis_req", 32'(MemReq), 32'h0);
        chk("mis_regwr", 32'(MEMRegWrite), 32'h0);
        chk("mis_stall", 32'(MEMStall), 32'h0);
        EXValid = 1'b0;
        step();
        chk("mis_err_pulse", 32'(MisalignErr), 32'h0);
        chk("mis_req_after", 32'(MemReq), 32'h0);

        // Misaligned half, reserved size, read+write together
        ex_mem(1'b1, 1'b0, 2'b01, 1'b0, 32'h41, 32'h0, 5'd8, 1'b1);
        step();
        chk("mis_half", 32'(MisalignErr), 32'h1);
        ex_mem(1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 5'd8, 1'b1);
        step();
        chk("rsvd_size", 32'(MisalignErr), 32'h1);
        ex_mem(1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 5'd8, 1'b1);
        step();
        chk("rd_and_wr", 32'(MisalignErr), 32'h1);
        chk("rd_and_wr_req", 32'(MemReq), 32'h0);
        EXValid = 1'b0;
        step();

        // Reset during ACCESS, then a stray ack
        ex_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 5'd10, 1'b1);
        step();
        chk("ra_req", 32'(MemReq), 32'h1);
        EXValid = 1'b0; Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("ra_req0", 32'(MemReq), 32'h0);
        chk("ra_stall", 32'(MEMStall), 32'h0);
        chk("ra_addr", MemAddr, 32'h0);
        chk("ra_be", 32'(MemByteEn), 32'h0);
        chk("ra_data", MEMData, 32'h0);
        MemAck = 1'b1; MemRData = 32'h55AA55AA;
        step();
        MemAck = 1'b0;
        chk("stray_req", 32'(MemReq), 32'h0);
        chk("stray_regwr", 32'(MEMRegWrite), 32'h0);
        chk("stray_data", MEMData, 32'h0);
        chk("stray_rd", 32'(MEMRd), 32'h0);
        chk("stray_stall", 32'(MEMStall), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
